alu_addsub_serial: RTL and testbench

//   Multi-cycle add/subtract unit with the OF/CF/ZF/SF/PF flag set, for the ALU datapath.

---
 rtl/alu_addsub_serial.sv | 119 +++++++++++
 tb/tb_alu_addsub_serial.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_addsub_serial.sv
// Serial add/subtract unit: a WIDTH-bit operation is processed SLICE bits per clock
// through one ripple slice and a carry register, producing result plus OF/CF/ZF/SF/PF.
module alu_addsub_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             ctrl_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             of_o,
    output logic             cf_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             pf_o,
    output logic             state_o
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bc_q;     // B already inverted for subtract
    logic             sub_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] s_q;
    logic             done_q;
    logic             of_q, cf_q, zf_q, sf_q, pf_q;

    logic [SLICE-1:0] a_sl, b_sl, sum;
    logic             c_out, c_msb;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        a_sl  = a_q[k_q*SLICE +: SLICE];
        b_sl  = bc_q[k_q*SLICE +: SLICE];
        {c_out, sum} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from its sum bit and operand bits.
        c_msb = sum[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];
        res_d = res_q;
        res_d[k_q*SLICE +: SLICE] = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            bc_q    <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            done_q  <= 1'b0;
            of_q    <= 1'b0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        bc_q    <= ctrl_i ? ~b_i : b_i;
                        sub_q   <= ctrl_i;
                        // Subtract carries in ~cin; add carries in cin.
                        carry_q <= ctrl_i ^ cin_i;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= c_out;
                    k_q     <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        s_q     <= res_d;
                        of_q    <= c_msb ^ c_out;
                        cf_q    <= sub_q ? ~c_out : c_out;
                        zf_q    <= ~|res_d;
                        sf_q    <= res_d[WIDTH-1];
                        pf_q    <= ^res_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign done_o  = done_q;
    assign s_o     = s_q;
    assign of_o    = of_q;
    assign cf_o    = cf_q;
    assign zf_o    = zf_q;
    assign sf_o    = sf_q;
    assign pf_o    = pf_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_alu_addsub_serial.sv
// Bench for alu_addsub_serial: directed flag/handshake/reset cases on SLICE=4, then
// random operations on SLICE=1/4/16 instances against an integer-arithmetic model.
module tb_alu_addsub_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ctrl;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;

    // Index 0: SLICE=4, 1: SLICE=1, 2: SLICE=16
    logic [2:0]  rdy, dn, of_v, cf_v, zf_v, sf_v, pf_v, st_v;
    logic [15:0] s_v [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc [3];
    int done_cnt [3];

    localparam int LAT [3] = '{4, 16, 1};

    alu_addsub_serial #(.WIDTH(16), .SLICE(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .ctrl_i(ctrl), .cin_i(cin),
        .a_i(a), .b_i(b), .ready_o(rdy[0]), .done_o(dn[0]), .s_o(s_v[0]),
        .of_o(of_v[0]), .cf_o(cf_v[0]), .zf_o(zf_v[0]), .sf_o(sf_v[0]), .pf_o(pf_v[0]),
        .state_o(st_v[0]));

    alu_addsub_serial #(.WIDTH(16), .SLICE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .ctrl_i(ctrl), .cin_i(cin),
        .a_i(a), .b_i(b), .ready_o(rdy[1]), .done_o(dn[1]), .s_o(s_v[1]),
        .of_o(of_v[1]), .cf_o(cf_v[1]), .zf_o(zf_v[1]), .sf_o(sf_v[1]), .pf_o(pf_v[1]),
        .state_o(st_v[1]));

    alu_addsub_serial #(.WIDTH(16), .SLICE(16)) u_s16 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .ctrl_i(ctrl), .cin_i(cin),
        .a_i(a), .b_i(b), .ready_o(rdy[2]), .done_o(dn[2]), .s_o(s_v[2]),
        .of_o(of_v[2]), .cf_o(cf_v[2]), .zf_o(zf_v[2]), .sf_o(sf_v[2]), .pf_o(pf_v[2]),
        .state_o(st_v[2]));

    // ---------------- clock / cycle bookkeeping ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 3; i++) begin
            done_cyc[i] = -100;
            done_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dn[i]) begin
                done_cyc[i] = cyc;
                done_cnt[i] = done_cnt[i] + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    // Returns {s, OF, CF, ZF, SF, PF} from plain integer arithmetic.
    function automatic logic [20:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic msub, input logic mcin);
        int          ua, ub, uc, sa, sb, sv;
        logic [15:0] r;
        logic        o, c;
        ua = int'(ma);
        ub = int'(mb);
        uc = mcin ? 1 : 0;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            r  = 16'(ua + ub + uc);
            c  = (ua + ub + uc) > 65535;
            sv = sa + sb + uc;
        end else begin
            r  = 16'(ua - ub - uc);
            c  = ua < (ub + uc);
            sv = sa - sb - uc;
        end
        o = (sv > 32767) || (sv < -32768);
        return {r, o, c, (r == 16'h0000), r[15], ^r};
    endfunction

    function automatic logic [20:0] observed(input int i);
        return {s_v[i], of_v[i], cf_v[i], zf_v[i], sf_v[i], pf_v[i]};
    endfunction

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [15:0] la, input logic [15:0] lb,
                          input logic lctrl, input logic lcin);
        a     = la;
        b     = lb;
        ctrl  = lctrl;
        cin   = lcin;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int i, input string tag);
        int g;
        g = 0;
        while (!dn[i] && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_done_seen"}, 32'(dn[i]), 32'd1);
    endtask

    task automatic wait_all_ready();
        int g;
        g = 0;
        while (rdy !== 3'b111 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("all_ready", 32'(rdy), 32'h7);
    endtask

    task automatic check_op(input string tag, input logic [15:0] es, input logic [4:0] ef);
        check({tag, "_lat"}, 32'(cyc - acc_cyc), 32'd4);
        check({tag, "_s"}, 32'(s_v[0]), 32'(es));
        check({tag, "_flags"}, 32'({of_v[0], cf_v[0], zf_v[0], sf_v[0], pf_v[0]}), 32'(ef));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [20:0] exp_r;
        int          dcnt;

        rst_n = 1'b0;
        start = 1'b0;
        ctrl  = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_done", 32'(dn[0]), 32'd0);
        check("rst_s", 32'(s_v[0]), 32'd0);
        check("rst_flags", 32'({of_v[0], cf_v[0], zf_v[0], sf_v[0], pf_v[0]}), 32'b00100);
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("busy_ready", 32'(rdy[0]), 32'd0);
        wait_done(0, "add_of");
        check_op("add_of", 16'h8000, 5'b10011);

        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(0, "add_wrap");
        check_op("add_wrap", 16'h0000, 5'b01100);

        launch(16'h0000, 16'h0001, 1'b1, 1'b0);
        wait_done(0, "sub_borrow");
        check_op("sub_borrow", 16'hFFFF, 5'b01010);

        launch(16'h8000, 16'h0001, 1'b1, 1'b0);
        wait_done(0, "sub_of");
        check_op("sub_of", 16'h7FFF, 5'b10001);

        // Start pulsed mid-RUN with other operands must be ignored.
        launch(16'h0003, 16'h0004, 1'b0, 1'b0);
        a     = 16'hAAAA;
        b     = 16'h5555;
        ctrl  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, "busy_ign");
        check_op("busy_ign", 16'h0007, 5'b00001);
        check("done_cycle_ready", 32'(rdy[0]), 32'd1);

        launch(16'h1234, 16'h4321, 1'b0, 1'b1);
        wait_done(0, "b2b");
        check_op("b2b", 16'h5556, 5'b00000);

        // Asynchronous reset during slice 2 of an operation.
        launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(rdy[0]), 32'd1);
        check("mid_rst_done", 32'(dn[0]), 32'd0);
        check("mid_rst_s", 32'(s_v[0]), 32'd0);
        check("mid_rst_flags", 32'({of_v[0], cf_v[0], zf_v[0], sf_v[0], pf_v[0]}), 32'b00100);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = done_cnt[0];
        repeat (8) @(negedge clk);
        check("no_done_after_rst", 32'(done_cnt[0] - dcnt), 32'd0);

        launch(16'h00FF, 16'h0F0F, 1'b1, 1'b1);
        wait_done(0, "post_rst");
        exp_r = model(16'h00FF, 16'h0F0F, 1'b1, 1'b1);
        check_op("post_rst", exp_r[20:5], exp_r[4:0]);

        // Random operations on all three slice widths in lockstep.
        wait_all_ready();
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] ra, rb;
            logic        rc, rcin;
            int          d0, gap;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            exp_r = model(ra, rb, rc, rcin);
            d0 = done_cnt[0];
            launch(ra, rb, rc, rcin);
            wait_done(1, "rnd");
            check("rnd_lat_s1", 32'(cyc - acc_cyc), 32'(LAT[1]));
            check("rnd_lat_s4", 32'(done_cyc[0] - acc_cyc), 32'(LAT[0]));
            check("rnd_lat_s16", 32'(done_cyc[2] - acc_cyc), 32'(LAT[2]));
            check("rnd_pulses_s4", 32'(done_cnt[0] - d0), 32'd1);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rnd_res_i%0d", i), 32'(observed(i)), 32'(exp_r));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
